pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_ctrl_perf.sv | 41 ++++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// pipeline stage indices and flush counter sizing.
package pipe_ctrl_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   localparam int STG_PC    = 0;
   localparam int STG_IF_ID = 1;
   localparam int STG_ID_EX = 2;

   localparam int CNT_W = 4;

   // Value loaded on a redirect: the redirect cycle itself is the first
   // cycle of the flush window, so the FLUSH state covers the remainder.
   function automatic logic [CNT_W-1:0] flush_load(input int flush_cycles);
      return CNT_W'(flush_cycles - 1);
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Free-running stall/flush cycle counters for the pipeline controller.
// Both counters wrap at 2^32 and clear on reset.
module pipe_ctrl_perf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_any_i,
   input  logic        flush_any_i,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;
   logic [31:0] stall_cnt_d;
   logic [31:0] flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_any_i) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (flush_any_i) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: redirect select, per-stage flush/stall masks.
// Define PIPE_CTRL_PERF_EN to add stall_cnt_o / flush_cnt_o cycle counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no flush window open; flush only on a same-cycle redirect
//   ST_FLUSH | inside a flush window; cnt_q cycles remain including this one
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int STAGES       = STG_ID_EX + 1,
   parameter int FLUSH_CYCLES = 2,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_ex_i,
   input  logic              clint_jump_i,
   input  logic [ADDR_W-1:0] clint_addr_i,
   input  logic              clint_hold_i,
   output logic              jump_flag_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic [STAGES-1:0] stall_o,
   output logic [STAGES-1:0] flush_o,
   output logic              busy_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       flush_cnt_o
`endif
);

   localparam logic [CNT_W-1:0]  CNT_LOAD = flush_load(FLUSH_CYCLES);
   localparam logic [STAGES-1:0] ALL_STG  = '1;
   localparam logic [STAGES-1:0] EX_STG   = ALL_STG >> 1;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;

   logic              redirect;
   logic              flush_active;
   logic [STAGES-1:0] hold_mask;
   logic [STAGES-1:0] flush_mask;

   assign redirect     = clint_jump_i | jump_flag_i;
   assign flush_active = redirect | (state_q == ST_FLUSH);

   always_comb begin
      jump_addr_o = '0;
      if (clint_jump_i) begin
         jump_addr_o = clint_addr_i;
      end else if (jump_flag_i) begin
         jump_addr_o = jump_addr_i;
      end
   end

   // pc_reg never bubbles: it consumes the redirect target instead.
   always_comb begin
      flush_mask = '0;
      for (int s = 0; s < STAGES; s++) begin
         flush_mask[s] = flush_active && (s >= STG_IF_ID);
      end
      flush_mask[STG_PC] = 1'b0;
   end

   always_comb begin
      hold_mask = '0;
      if (clint_hold_i) begin
         hold_mask = ALL_STG;
      end else if (hold_ex_i) begin
         hold_mask = EX_STG;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else if (redirect) begin
         if (FLUSH_CYCLES == 1) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            state_q <= ST_FLUSH;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
         end
      end else if (state_q == ST_FLUSH) begin
         cnt_q <= cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end
      end
   end

   assign jump_flag_o = redirect;
   assign flush_o     = flush_mask;
   assign stall_o     = hold_mask & ~flush_mask;
   assign busy_o      = busy_q;

`ifdef PIPE_CTRL_PERF_EN
   pipe_ctrl_perf u_perf (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_any_i (|stall_o),
      .flush_any_i (|flush_o),
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (FLUSH_CYCLES 2 and 4) against a
// cycle-index window model, plus directed literal expectations.
module tb_pipe_ctrl;

   localparam int AW = 32;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          jf    = 1'b0;
   logic          cj    = 1'b0;
   logic          hx    = 1'b0;
   logic          ch    = 1'b0;
   logic [AW-1:0] ja    = '0;
   logic [AW-1:0] ca    = '0;

   logic          a_jf, b_jf, a_bz, b_bz;
   logic [AW-1:0] a_ja, b_ja;
   logic [2:0]    a_st, a_fl, b_st, b_fl;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]   a_sc, a_fc, b_sc, b_fc;
`endif

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl #(.STAGES(3), .FLUSH_CYCLES(2), .ADDR_W(AW)) u_a (
      .clk(clk), .rst_n(rst_n),
      .jump_flag_i(jf), .jump_addr_i(ja), .hold_ex_i(hx),
      .clint_jump_i(cj), .clint_addr_i(ca), .clint_hold_i(ch),
      .jump_flag_o(a_jf), .jump_addr_o(a_ja), .stall_o(a_st),
      .flush_o(a_fl), .busy_o(a_bz)
`ifdef PIPE_CTRL_PERF_EN
      , .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
`endif
   );

   pipe_ctrl #(.STAGES(3), .FLUSH_CYCLES(4), .ADDR_W(AW)) u_b (
      .clk(clk), .rst_n(rst_n),
      .jump_flag_i(jf), .jump_addr_i(ja), .hold_ex_i(hx),
      .clint_jump_i(cj), .clint_addr_i(ca), .clint_hold_i(ch),
      .jump_flag_o(b_jf), .jump_addr_o(b_ja), .stall_o(b_st),
      .flush_o(b_fl), .busy_o(b_bz)
`ifdef PIPE_CTRL_PERF_EN
      , .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
`endif
   );

   // Model: a window of fc cycles opens at the cycle index of the last redirect.
   int          cyc = 0;
   int          fc [2] = '{2, 4};
   bit          have [2] = '{1'b0, 1'b0};
   int          redir_at [2] = '{0, 0};
   int unsigned m_sc [2] = '{0, 0};
   int unsigned m_fc [2] = '{0, 0};

   function automatic bit in_window(input int k);
      return have[k] && ((cyc - redir_at[k]) < fc[k]);
   endfunction

   function automatic logic [2:0] e_flush(input int k);
      return ((cj | jf) || in_window(k)) ? 3'b110 : 3'b000;
   endfunction

   function automatic logic [2:0] e_stall(input int k);
      logic [2:0] m;
      m = ch ? 3'b111 : (hx ? 3'b011 : 3'b000);
      return m & ~e_flush(k);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst_n) begin
            if (e_stall(k) != 3'b000) m_sc[k]++;
            if (e_flush(k) != 3'b000) m_fc[k]++;
            if (cj | jf) begin
               have[k]     = 1'b1;
               redir_at[k] = cyc;
            end
         end else begin
            have[k] = 1'b0;
         end
      end
      cyc++;
   end

   always @(negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         have[k] = 1'b0;
         m_sc[k] = 0;
         m_fc[k] = 0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         logic [AW-1:0] ea;
         ea = cj ? ca : (jf ? ja : '0);
         chk("a_jump_flag", a_jf, cj | jf);
         chk("a_jump_addr", a_ja, ea);
         chk("a_flush", a_fl, e_flush(0));
         chk("a_stall", a_st, e_stall(0));
         chk("a_busy", a_bz, in_window(0));
         chk("b_jump_flag", b_jf, cj | jf);
         chk("b_jump_addr", b_ja, ea);
         chk("b_flush", b_fl, e_flush(1));
         chk("b_stall", b_st, e_stall(1));
         chk("b_busy", b_bz, in_window(1));
`ifdef PIPE_CTRL_PERF_EN
         chk("a_stall_cnt", a_sc, m_sc[0]);
         chk("a_flush_cnt", a_fc, m_fc[0]);
         chk("b_stall_cnt", b_sc, m_sc[1]);
         chk("b_flush_cnt", b_fc, m_fc[1]);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      jf = 1'b0; cj = 1'b0; hx = 1'b0; ch = 1'b0; ja = '0; ca = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cmp_en = 1'b1;
      @(negedge clk);
      chk("rst_flush", a_fl, 3'b000);
      chk("rst_stall", a_st, 3'b000);
      chk("rst_busy", a_bz, 1'b0);
      chk("rst_jump_addr", a_ja, 32'h0);
      step(); step();
      rst_n = 1'b1;
      step();

      // single ex redirect
      step(); jf = 1'b1; ja = 32'h0000_0100;
      @(negedge clk);
      chk("j1_flag", a_jf, 1'b1);
      chk("j1_addr", a_ja, 32'h100);
      chk("j1_flush0", a_fl, 3'b110);
      chk("j1_busy0", a_bz, 1'b0);
      step(); idle();
      @(negedge clk);
      chk("j1_flush1", a_fl, 3'b110);
      chk("j1_busy1", a_bz, 1'b1);
      step();
      @(negedge clk);
      chk("j1_flush2", a_fl, 3'b000);
      chk("j1_busy2", a_bz, 1'b0);

      // ex hold then clint hold
      for (int i = 0; i < 3; i++) begin
         step(); hx = 1'b1;
         @(negedge clk);
         chk("hex_stall", a_st, 3'b011);
         chk("hex_flush", a_fl, 3'b000);
      end
      step(); hx = 1'b0; ch = 1'b1;
      @(negedge clk);
      chk("hcl_stall", a_st, 3'b111);
      step(); idle();
      @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
      chk("perf_flush_cnt", a_fc, 32'd2);
      chk("perf_stall_cnt", a_sc, 32'd4);
`endif
      repeat (3) step();

      // simultaneous clint and ex redirect
      step(); cj = 1'b1; ca = 32'h200; jf = 1'b1; ja = 32'h100;
      @(negedge clk);
      chk("both_addr", a_ja, 32'h200);
      chk("both_flag", a_jf, 1'b1);
      chk("both_flush0", a_fl, 3'b110);
      step(); idle();
      @(negedge clk);
      chk("both_flush1", a_fl, 3'b110);
      chk("both_busy1", a_bz, 1'b1);
      step();
      @(negedge clk);
      chk("both_flush2", a_fl, 3'b000);
      chk("both_busy2", a_bz, 1'b0);
      repeat (3) step();

      // flush beats stall while ex hold is held
      step(); hx = 1'b1;
      @(negedge clk);
      chk("hf_stall0", a_st, 3'b011);
      step(); jf = 1'b1; ja = 32'h40;
      @(negedge clk);
      chk("hf_stall1", a_st, 3'b001);
      chk("hf_flush1", a_fl, 3'b110);
      step(); jf = 1'b0; ja = '0;
      @(negedge clk);
      chk("hf_stall2", a_st, 3'b001);
      step();
      @(negedge clk);
      chk("hf_stall3", a_st, 3'b011);
      step(); idle();
      repeat (4) step();

      // FLUSH_CYCLES=4: restart two cycles in gives six flush cycles
      step(); jf = 1'b1; ja = 32'h300;
      @(negedge clk);
      chk("rs_flush0", b_fl, 3'b110);
      for (int i = 1; i <= 6; i++) begin
         step(); jf = (i == 2);
         @(negedge clk);
         chk("rs_flush", b_fl, (i <= 5) ? 3'b110 : 3'b000);
      end
      chk("rs_busy_end", b_bz, 1'b0);
      idle();
      repeat (2) step();

      // reset in the middle of a window
      step(); jf = 1'b1; ja = 32'h400;
      step(); jf = 1'b0; ja = '0;
      step();
      step(); rst_n = 1'b0;
      @(negedge clk);
      chk("mr_flush_rst", b_fl, 3'b000);
      chk("mr_busy_rst", b_bz, 1'b0);
      step(); rst_n = 1'b1;
      @(negedge clk);
      chk("mr_flush_rel", b_fl, 3'b000);
      chk("mr_busy_rel", b_bz, 1'b0);
      step();
      @(negedge clk);
      chk("mr_flush_after", b_fl, 3'b000);

      // mixed input table
      for (int i = 0; i < 32; i++) begin
         step();
         cj = i[0]; jf = i[1]; hx = i[2]; ch = i[3];
         ja = 32'h1000 + 32'(i);
         ca = 32'h2000 + 32'(i);
      end
      step(); idle();
      repeat (6) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
